// File: rtl/decoder_stage_pipe.sv
// RV32I(+Zicsr, optional M) main decoder registered through a 2-entry skid buffer.
// Also keeps a saturating count of illegal instruction words accepted since reset.
module decoder_stage_pipe #(
    parameter int ENABLE_M   = 1,
    parameter int ENABLE_CSR = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       a_sel_o,
    output logic [2:0]       b_sel_o,
    output logic [4:0]       alu_op_o,
    output logic [2:0]       csr_op_o,
    output logic             csr_we_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [2:0]       mem_size_o,
    output logic             gpr_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             mret_o,
    output logic             illegal_instr_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [4:0] ALU_ADD  = 5'b0_0000;
    localparam logic [4:0] ALU_SLT  = 5'b0_0010;
    localparam logic [4:0] ALU_SLTU = 5'b0_0011;
    localparam logic [4:0] ALU_SUB  = 5'b0_1000;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [2:0] b_sel;
        logic [4:0] alu_op;
        logic [2:0] csr_op;
        logic       csr_we;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic [1:0] wb_sel;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mret;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t           state_q, state_d;
    ctrl_t            main_q, skid_q, dec;
    logic [CNT_W-1:0] cnt_q;
    logic             legal, accept, pop;
    logic             ld_main_in, ld_main_skid, ld_skid;
    logic [2:0]       f3;
    logic [6:0]       f7;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (instr_i[6:0])
            7'b0110111: begin  // LUI
                legal = 1'b1; dec.a_sel = 2'd2; dec.b_sel = 3'd2; dec.gpr_we = 1'b1;
            end
            7'b0010111: begin  // AUIPC
                legal = 1'b1; dec.a_sel = 2'd1; dec.b_sel = 3'd2; dec.gpr_we = 1'b1;
            end
            7'b1101111: begin  // JAL: ALU produces the link address PC+4
                legal = 1'b1; dec.a_sel = 2'd1; dec.b_sel = 3'd4; dec.gpr_we = 1'b1;
                dec.jal = 1'b1;
            end
            7'b1100111: begin  // JALR
                legal = (f3 == 3'd0); dec.a_sel = 2'd1; dec.b_sel = 3'd4;
                dec.gpr_we = 1'b1; dec.jalr = 1'b1;
            end
            7'b1100011: begin  // branches compare rs1/rs2 in the ALU
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                dec.branch = 1'b1;
                dec.alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            end
            7'b0000011: begin  // loads
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                dec.b_sel = 3'd1; dec.mem_req = 1'b1; dec.mem_size = f3;
                dec.gpr_we = 1'b1; dec.wb_sel = 2'd1;
            end
            7'b0100011: begin  // stores
                legal = (f3 <= 3'd2);
                dec.b_sel = 3'd3; dec.mem_req = 1'b1; dec.mem_we = 1'b1; dec.mem_size = f3;
            end
            7'b0010011: begin  // OP-IMM: only the shifts constrain funct7
                dec.b_sel = 3'd1; dec.gpr_we = 1'b1;
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00); dec.alu_op = {2'b00, f3};
                end else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20); dec.alu_op = {1'b0, instr_i[30], f3};
                end else begin
                    legal = 1'b1; dec.alu_op = {2'b00, f3};
                end
            end
            7'b0110011: begin  // OP
                dec.gpr_we = 1'b1;
                if (f7 == 7'h00) begin
                    legal = 1'b1; dec.alu_op = {2'b00, f3};
                end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    legal = 1'b1; dec.alu_op = {2'b01, f3};
                end else if (f7 == 7'h01 && ENABLE_M != 0) begin
                    legal = 1'b1; dec.alu_op = {2'b10, f3};
                end
            end
            7'b0001111: legal = (f3 == 3'd0);  // FENCE executes as a no-op
            7'b1110011: begin
                if (f3 == 3'd0) begin
                    if (instr_i == 32'h0000_0073 || instr_i == 32'h0010_0073) begin
                        legal = 1'b1;
                    end else if (instr_i == 32'h3020_0073 && ENABLE_CSR != 0) begin
                        legal = 1'b1; dec.mret = 1'b1;
                    end
                end else if (f3 != 3'd4 && ENABLE_CSR != 0) begin
                    // CSRRS/CSRRC with rs1=x0 only read the CSR
                    legal = 1'b1; dec.csr_op = f3; dec.gpr_we = 1'b1; dec.wb_sel = 2'd2;
                    dec.csr_we = !(f3[1] && instr_i[19:15] == 5'd0);
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready_o  = (state_q != S_FULL);
    assign out_valid_o = (state_q != S_EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) begin
                    state_d = S_ONE; ld_main_in = 1'b1;
                end
                S_ONE: begin
                    if (accept && pop) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_d = S_FULL; ld_skid = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: if (pop) begin
                    state_d = S_ONE; ld_main_skid = 1'b1;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Payload registers carry no reset; outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (ld_main_in)        main_q <= dec;
        else if (ld_main_skid) main_q <= skid_q;
        if (ld_skid)           skid_q <= dec;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (accept && dec.illegal && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    ctrl_t out_c;
    assign out_c = out_valid_o ? main_q : '0;

    assign a_sel_o         = out_c.a_sel;
    assign b_sel_o         = out_c.b_sel;
    assign alu_op_o        = out_c.alu_op;
    assign csr_op_o        = out_c.csr_op;
    assign csr_we_o        = out_c.csr_we;
    assign mem_req_o       = out_c.mem_req;
    assign mem_we_o        = out_c.mem_we;
    assign mem_size_o      = out_c.mem_size;
    assign gpr_we_o        = out_c.gpr_we;
    assign wb_sel_o        = out_c.wb_sel;
    assign branch_o        = out_c.branch;
    assign jal_o           = out_c.jal;
    assign jalr_o          = out_c.jalr;
    assign mret_o          = out_c.mret;
    assign illegal_instr_o = out_c.illegal;
    assign illegal_cnt_o   = cnt_q;

endmodule
